// File: rtl/control_red_serial.sv
`default_nettype none
// ============================================================================
// Module      : control_red_serial
// Description : Bit-serial sequencer for the iterative comparison network.
//               One typical cell is evaluated per clock, LSB first, with the
//               inter-cell signal W held in a flip-flop. Once all N bits are
//               consumed the final-cell function Z = !W is registered, so
//               Z = 1 exactly when A <= B (unsigned).
// Ports       : clk      - system clock, rising edge
//               reset_n  - asynchronous active-low reset
//               inicio   - start request (accepted only when idle)
//               A, B     - N-bit operands, captured when start is accepted
//               ocupado  - high while an operation is in progress
//               listo    - one-cycle pulse, Z valid
//               Z        - result, held until the next listo
//               W_actual - current W register (debug / observation)
// Revision    : 1.0 - initial release
// ============================================================================
module control_red_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ocupado,
    output logic         listo,
    output logic         Z,
    output logic         W_actual
);

    localparam int c_CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(N - 1);

    localparam logic [1:0] c_REPOSO = 2'd0;
    localparam logic [1:0] c_ITERA  = 2'd1;
    localparam logic [1:0] c_FIN    = 2'd2;

    logic [1:0]         r_state;
    logic [N-1:0]       r_sr_a;
    logic [N-1:0]       r_sr_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_w;
    logic               r_z;
    logic               r_listo;
    logic               r_ocupado;
    logic               w_w_next;

    // Typical cell: a strict win on this bit sets W; equal bits carry the
    // decision from the lower-order bits; a loss on this bit clears it.
    assign w_w_next = (r_sr_a[0] & ~r_sr_b[0]) |
                      (r_w & ~(r_sr_a[0] ^ r_sr_b[0]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_REPOSO;
            r_sr_a    <= '0;
            r_sr_b    <= '0;
            r_cnt     <= '0;
            r_w       <= 1'b0;
            r_z       <= 1'b0;
            r_listo   <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            // listo defaults low so it can only ever be a single-cycle pulse
            r_listo <= 1'b0;
            case (r_state)
                c_REPOSO: begin
                    if (inicio) begin
                        r_sr_a    <= A;
                        r_sr_b    <= B;
                        r_w       <= 1'b0;
                        r_cnt     <= '0;
                        r_ocupado <= 1'b1;
                        r_state   <= c_ITERA;
                    end
                end
                c_ITERA: begin
                    r_w    <= w_w_next;
                    r_sr_a <= {1'b0, r_sr_a[N-1:1]};
                    r_sr_b <= {1'b0, r_sr_b[N-1:1]};
                    // Counter stops at N-1, so it never wraps within an operation
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_FIN: begin
                    r_z       <= ~r_w;
                    r_listo   <= 1'b1;
                    r_ocupado <= 1'b0;
                    r_state   <= c_REPOSO;
                end
                default: begin
                    r_ocupado <= 1'b0;
                    r_state   <= c_REPOSO;
                end
            endcase
        end
    end

    assign ocupado  = r_ocupado;
    assign listo    = r_listo;
    assign Z        = r_z;
    assign W_actual = r_w;

endmodule
`default_nettype wire
